// File: rtl/icmp_rx_buffer_if.sv
// icmp_rx_buffer_if: bundle between the IP receive path, the ICMP
// receive buffer and the echo-reply coder.
// Signals:
//   RX_DATA/RX_VLD/RX_ERR  : message bytes from the IP receive path
//   ICMP_EN/ICMP_HEADER    : header strobe and packed header to coder
//   ICMP_DATA_REQ          : coder request for payload replay
//   ICMP_IN_DATA/_VLD      : replayed payload bytes
//   BUSY/DROP              : held-message flag, discard pulse
// Modports: master = upstream and coder side, slave = buffer.
interface icmp_rx_buffer_if;
   logic [7:0]  RX_DATA;
   logic        RX_VLD;
   logic        RX_ERR;
   logic        ICMP_EN;
   logic [67:0] ICMP_HEADER;
   logic        ICMP_DATA_REQ;
   logic [7:0]  ICMP_IN_DATA;
   logic        ICMP_IN_DATA_VLD;
   logic        BUSY;
   logic        DROP;

   modport master (
      output RX_DATA, RX_VLD, RX_ERR, ICMP_DATA_REQ,
      input  ICMP_EN, ICMP_HEADER, ICMP_IN_DATA,
      input  ICMP_IN_DATA_VLD, BUSY, DROP
   );

   modport slave (
      input  RX_DATA, RX_VLD, RX_ERR, ICMP_DATA_REQ,
      output ICMP_EN, ICMP_HEADER, ICMP_IN_DATA,
      output ICMP_IN_DATA_VLD, BUSY, DROP
   );
endinterface

// File: rtl/icmp_rx_buffer.sv
// icmp_rx_buffer: captures one ICMP echo request, buffers its payload,
// hands the coder a header with payload checksum, replays on request.
// Ports: CLK, RST (async, active-high), icmp_if (icmp_rx_buffer_if.slave).
// Parameters: BUF_DEPTH (payload bytes), ADDR_W (2**ADDR_W >= BUF_DEPTH).
// Option: define ICMP_RX_CSUM_CHECK_EN to verify the received checksum.
module icmp_rx_buffer #(
   parameter int BUF_DEPTH = 1024,
   parameter int ADDR_W    = 10
) (
   input logic              CLK,
   input logic              RST,
   icmp_rx_buffer_if.slave  icmp_if
);

   typedef enum logic [2:0] {
      IDLE, RECV, CHECK, ISSUE, WAIT_REQ, REPLAY, DRAIN
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(BUF_DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

   function automatic logic [15:0] oc_add(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'b0, s[16]};
   endfunction

   // main message FSM, plus a receive-side tracker (IDLE/DRAIN)
   // that swallows runs arriving while a message is held so the
   // replay in progress is never stalled
   state_t state_q, state_d;
   state_t drn_q, drn_d;

   logic [7:0]    type_q, code_q, hi_q;
   logic [15:0]   id_q, seq_q, acc_q;
   logic [3:0]    hcnt_q;
   logic [ADDR_W:0] plen_q, rcnt_q;
   logic          ovf_q, err_q;
   logic [67:0]   hdr_q;
`ifdef ICMP_RX_CSUM_CHECK_EN
   logic [15:0]   rcs_q;
`endif

   logic [7:0]    mem [0:BUF_DEPTH-1];
   logic [7:0]    rd_q;

   logic          busy, bad, csum_bad, ld_hdr, drop;
   logic          rd_last, wr_en, rd_en, pay_byte;
   logic [15:0]   sum_fin;
   logic [ADDR_W-1:0] rd_addr, wr_addr;

   assign busy = (state_q == ISSUE) || (state_q == WAIT_REQ)
              || (state_q == REPLAY);

   // odd trailing byte is the high half of a zero-padded word
   assign sum_fin = plen_q[0] ? oc_add(acc_q, {hi_q, 8'h00}) : acc_q;

`ifdef ICMP_RX_CSUM_CHECK_EN
   logic [15:0] tot;
   assign tot = oc_add(oc_add(oc_add(oc_add(sum_fin,
                  {type_q, code_q}), rcs_q), id_q), seq_q);
   assign csum_bad = (tot != 16'hFFFF);
`else
   assign csum_bad = 1'b0;
`endif

   assign bad = (type_q != 8'd8) || (code_q != 8'd0)
             || (hcnt_q != 4'd8) || ovf_q || err_q || csum_bad;

   assign rd_last  = ((rcnt_q + ONE_C) == plen_q);
   assign pay_byte = (state_q == RECV) && icmp_if.RX_VLD
                  && (hcnt_q == 4'd8);
   assign wr_en    = pay_byte && (plen_q != DEPTH_C);
   assign wr_addr  = plen_q[ADDR_W-1:0];
   // address 0 is prefetched while waiting so byte 0 is ready
   // the cycle after the request
   assign rd_en    = (state_q == WAIT_REQ) || (state_q == REPLAY);
   assign rd_addr  = (state_q == REPLAY)
                   ? rcnt_q[ADDR_W-1:0] + ADDR_W'(1) : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         drn_q   <= IDLE;
      end else begin
         state_q <= state_d;
         drn_q   <= drn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drn_d   = drn_q;
      ld_hdr  = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         IDLE:
            if (icmp_if.RX_VLD && (drn_q == IDLE))
               state_d = RECV;
         RECV:
            if (!icmp_if.RX_VLD)
               state_d = CHECK;
         CHECK:
            if (bad) begin
               state_d = IDLE;
               drop    = 1'b1;
            end else begin
               state_d = ISSUE;
               ld_hdr  = 1'b1;
            end
         ISSUE:
            state_d = WAIT_REQ;
         WAIT_REQ:
            if (icmp_if.ICMP_DATA_REQ)
               state_d = (plen_q == '0) ? IDLE : REPLAY;
         REPLAY:
            if (rd_last)
               state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
      // a run that begins in CHECK or a held state is not ours
      unique case (drn_q)
         IDLE:
            if (icmp_if.RX_VLD && (state_q != IDLE)
                && (state_q != RECV))
               drn_d = DRAIN;
         DRAIN:
            if (!icmp_if.RX_VLD) begin
               drn_d = IDLE;
               drop  = 1'b1;
            end
         default:
            drn_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         type_q <= '0;
         code_q <= '0;
         hi_q   <= '0;
         id_q   <= '0;
         seq_q  <= '0;
         acc_q  <= '0;
         hcnt_q <= '0;
         plen_q <= '0;
         rcnt_q <= '0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
         hdr_q  <= '0;
`ifdef ICMP_RX_CSUM_CHECK_EN
         rcs_q  <= '0;
`endif
      end else begin
         if (ld_hdr)
            hdr_q <= {seq_q, id_q, 4'b0, sum_fin, code_q, type_q};
         if ((state_q == IDLE) && (state_d == RECV)) begin
            type_q <= icmp_if.RX_DATA;
            code_q <= '0;
            id_q   <= '0;
            seq_q  <= '0;
            acc_q  <= '0;
            hcnt_q <= 4'd1;
            plen_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= icmp_if.RX_ERR;
`ifdef ICMP_RX_CSUM_CHECK_EN
            rcs_q  <= '0;
`endif
         end
         if (state_q == RECV) begin
            err_q <= err_q | icmp_if.RX_ERR;
            if (icmp_if.RX_VLD) begin
               if (hcnt_q != 4'd8)
                  hcnt_q <= hcnt_q + 4'd1;
               case (hcnt_q)
                  4'd1: code_q <= icmp_if.RX_DATA;
`ifdef ICMP_RX_CSUM_CHECK_EN
                  4'd2: rcs_q[15:8] <= icmp_if.RX_DATA;
                  4'd3: rcs_q[7:0]  <= icmp_if.RX_DATA;
`else
                  4'd2, 4'd3: ;
`endif
                  4'd4: id_q[15:8]  <= icmp_if.RX_DATA;
                  4'd5: id_q[7:0]   <= icmp_if.RX_DATA;
                  4'd6: seq_q[15:8] <= icmp_if.RX_DATA;
                  4'd7: seq_q[7:0]  <= icmp_if.RX_DATA;
                  default: begin
                     if (plen_q == DEPTH_C) begin
                        ovf_q <= 1'b1;
                     end else begin
                        plen_q <= plen_q + ONE_C;
                        if (plen_q[0])
                           acc_q <= oc_add(acc_q,
                                    {hi_q, icmp_if.RX_DATA});
                        else
                           hi_q <= icmp_if.RX_DATA;
                     end
                  end
               endcase
            end
         end
         if (state_q == WAIT_REQ)
            rcnt_q <= '0;
         else if (state_q == REPLAY)
            rcnt_q <= rcnt_q + ONE_C;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en)
         mem[wr_addr] <= icmp_if.RX_DATA;
      if (rd_en)
         rd_q <= mem[rd_addr];
   end

   assign icmp_if.ICMP_EN          = (state_q == ISSUE);
   assign icmp_if.ICMP_HEADER      = hdr_q;
   assign icmp_if.ICMP_IN_DATA_VLD = (state_q == REPLAY);
   assign icmp_if.ICMP_IN_DATA     = (state_q == REPLAY) ? rd_q : 8'h00;
   assign icmp_if.BUSY             = busy;
   assign icmp_if.DROP             = drop;

endmodule

// File: tb/tb_icmp_rx_buffer.sv
// tb_icmp_rx_buffer: directed vector table plus hand-written
// sequences for drain-while-held, reset and request corner cases.
module tb_icmp_rx_buffer;

`ifdef ICMP_RX_CSUM_CHECK_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   icmp_rx_buffer_if bus();

   icmp_rx_buffer #(.BUF_DEPTH(64), .ADDR_W(6)) dut (
      .CLK(clk),
      .RST(rst),
      .icmp_if(bus.slave)
   );

   typedef struct {
      logic [7:0]  typ;
      logic [7:0]  code;
      logic [15:0] id;
      logic [15:0] seq;
      int          plen;
      logic [7:0]  base;
      int          step;
      int          hlen;
      int          err_at;
      bit          flip;
      bit          ok;
      int          cs;
   } vec_t;

   int n_chk = 0;
   int n_err = 0;
   int en_cnt = 0;
   int drop_cnt = 0;

   logic [7:0] msg_q[$];
   logic [7:0] pay_q[$];
   vec_t tv[11];

   always @(negedge clk) begin
      if (bus.ICMP_EN) en_cnt++;
      if (bus.DROP) drop_cnt++;
   end

   task automatic check(input string nm, input logic [67:0] act,
                        input logic [67:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ones_sum(input logic [7:0] q[$]);
      logic [31:0] s;
      logic [15:0] w;
      s = 0;
      for (int i = 0; i < q.size(); i += 2) begin
         w = {q[i], (i + 1 < q.size()) ? q[i+1] : 8'h00};
         s += {16'h0, w};
      end
      while (s[31:16] != 0)
         s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return s[15:0];
   endfunction

   task automatic build(input vec_t v);
      logic [15:0] cs;
      pay_q.delete();
      msg_q.delete();
      for (int i = 0; i < v.plen; i++)
         pay_q.push_back(v.base + 8'(i * v.step));
      msg_q = '{v.typ, v.code, 8'h00, 8'h00,
                v.id[15:8], v.id[7:0], v.seq[15:8], v.seq[7:0]};
      foreach (pay_q[i]) msg_q.push_back(pay_q[i]);
      cs = ~ones_sum(msg_q);
      if (v.flip) cs ^= 16'h0100;
      msg_q[2] = cs[15:8];
      msg_q[3] = cs[7:0];
      while (msg_q.size() > v.hlen + v.plen) void'(msg_q.pop_back());
   endtask

   task automatic send(input logic [7:0] m[$], input int err_at);
      foreach (m[i]) begin
         bus.RX_VLD  = 1'b1;
         bus.RX_DATA = m[i];
         bus.RX_ERR  = (i == err_at);
         tick();
      end
      bus.RX_VLD  = 1'b0;
      bus.RX_DATA = 8'h00;
      bus.RX_ERR  = 1'b0;
      tick();
   endtask

   task automatic do_replay(input string nm, input logic [7:0] q[$]);
      bus.ICMP_DATA_REQ = 1'b1;
      tick();
      bus.ICMP_DATA_REQ = 1'b0;
      foreach (q[i]) begin
         check($sformatf("%s_byte%0d", nm, i),
               {59'h0, bus.ICMP_IN_DATA_VLD, bus.ICMP_IN_DATA},
               {59'h0, 1'b1, q[i]});
         tick();
      end
      check({nm, "_end"}, {66'h0, bus.ICMP_IN_DATA_VLD, bus.BUSY},
            68'h0);
   endtask

   task automatic run_vec(input string nm, input vec_t v,
                          input bit rep);
      logic [67:0] h0, hx;
      logic [15:0] cs;
      int e0, d0;
      build(v);
      h0 = bus.ICMP_HEADER;
      e0 = en_cnt;
      d0 = drop_cnt;
      send(msg_q, v.err_at);
      check({nm, "_en_chk"}, {67'h0, bus.ICMP_EN}, 68'h0);
      tick();
      check({nm, "_en_iss"}, {67'h0, bus.ICMP_EN}, {67'h0, v.ok});
      tick();
      check({nm, "_en_cnt"}, 68'(en_cnt - e0), 68'(v.ok ? 1 : 0));
      check({nm, "_drop"}, 68'(drop_cnt - d0), 68'(v.ok ? 0 : 1));
      check({nm, "_busy"}, {67'h0, bus.BUSY}, {67'h0, v.ok});
      if (v.ok) begin
         cs = (v.cs >= 0) ? 16'(v.cs) : ones_sum(pay_q);
         hx = {v.seq, v.id, 4'h0, cs, v.code, v.typ};
         check({nm, "_hdr"}, bus.ICMP_HEADER, hx);
         if (rep) do_replay(nm, pay_q);
      end else begin
         check({nm, "_hdr_kept"}, bus.ICMP_HEADER, h0);
      end
   endtask

   initial begin : main
      vec_t a;
      logic [7:0] pa[$];
      logic [67:0] ha;
      int e0, d0;

      tv[0]  = '{8'h08, 8'h00, 16'h1234, 16'h0001, 32, 8'h00, 1,
                 8, -1, 1'b0, 1'b1, 'hF100};
      tv[1]  = '{8'h08, 8'h00, 16'h0002, 16'h0003, 3, 8'hAB, 'h22,
                 8, -1, 1'b0, 1'b1, 'h9ACE};
      tv[2]  = '{8'h00, 8'h00, 16'h0004, 16'h0005, 4, 8'h11, 1,
                 8, -1, 1'b0, 1'b0, -1};
      tv[3]  = '{8'h08, 8'h00, 16'h0006, 16'h0007, 0, 8'h00, 1,
                 6, -1, 1'b0, 1'b0, -1};
      tv[4]  = '{8'h08, 8'h00, 16'h0008, 16'h0009, 6, 8'h20, 1,
                 8, 10, 1'b0, 1'b0, -1};
      tv[5]  = '{8'h08, 8'h00, 16'h000A, 16'h000B, 65, 8'h10, 7,
                 8, -1, 1'b0, 1'b0, -1};
      tv[6]  = '{8'h08, 8'h00, 16'hBEEF, 16'hCAFE, 64, 8'h40, 3,
                 8, -1, 1'b0, 1'b1, -1};
      tv[7]  = '{8'h08, 8'h00, 16'h00AA, 16'h00BB, 0, 8'h00, 1,
                 8, -1, 1'b0, 1'b1, 0};
      tv[8]  = '{8'h08, 8'h00, 16'h4321, 16'h0010, 5, 8'h5A, 'h11,
                 8, -1, 1'b0, 1'b1, -1};
      tv[9]  = '{8'h08, 8'h00, 16'h4321, 16'h0010, 5, 8'h5A, 'h11,
                 8, -1, 1'b1, !CSUM_ON, -1};
      tv[10] = '{8'h08, 8'h01, 16'h0C0C, 16'h0D0D, 2, 8'h77, 1,
                 8, -1, 1'b0, 1'b0, -1};

      bus.RX_DATA = 8'h00;
      bus.RX_VLD = 1'b0;
      bus.RX_ERR = 1'b0;
      bus.ICMP_DATA_REQ = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_hdr", bus.ICMP_HEADER, 68'h0);
      check("rst_out", {60'h0, bus.ICMP_IN_DATA},
            68'h0);
      check("rst_flags", {64'h0, bus.ICMP_EN, bus.ICMP_IN_DATA_VLD,
            bus.BUSY, bus.DROP}, 68'h0);

      bus.ICMP_DATA_REQ = 1'b1;
      tick();
      bus.ICMP_DATA_REQ = 1'b0;
      check("req_idle", {66'h0, bus.ICMP_IN_DATA_VLD, bus.BUSY},
            68'h0);

      for (int i = 0; i < 11; i++)
         run_vec($sformatf("v%0d", i), tv[i], 1'b1);

      // second message arriving while held drains during replay
      a = tv[8];
      a.flip = 1'b0;
      a.plen = 8;
      run_vec("held", a, 1'b0);
      pa = pay_q;
      ha = bus.ICMP_HEADER;
      build(tv[2]);
      e0 = en_cnt;
      d0 = drop_cnt;
      fork
         do_replay("drn_rep", pa);
         send(msg_q, -1);
      join
      check("drn_drop", 68'(drop_cnt - d0), 68'd1);
      check("drn_en", 68'(en_cnt - e0), 68'd0);
      check("drn_hdr", bus.ICMP_HEADER, ha);

      // run starting in the last replay cycle is drained too
      run_vec("held2", a, 1'b0);
      build(tv[0]);
      e0 = en_cnt;
      d0 = drop_cnt;
      fork
         do_replay("lst_rep", pa);
         begin
            repeat (8) tick();
            send(msg_q, -1);
         end
      join
      repeat (2) tick();
      check("lst_drop", 68'(drop_cnt - d0), 68'd1);
      check("lst_en", 68'(en_cnt - e0), 68'd0);
      check("lst_busy", {67'h0, bus.BUSY}, 68'h0);
      run_vec("after", tv[1], 1'b1);

      // reset while a message is held
      run_vec("prerst", tv[8], 1'b0);
      d0 = drop_cnt;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {67'h0, bus.BUSY}, 68'h0);
      check("mid_rst_hdr", bus.ICMP_HEADER, 68'h0);
      tick();
      rst = 1'b0;
      bus.ICMP_DATA_REQ = 1'b1;
      tick();
      bus.ICMP_DATA_REQ = 1'b0;
      check("mid_rst_vld", {67'h0, bus.ICMP_IN_DATA_VLD}, 68'h0);
      check("mid_rst_drop", 68'(drop_cnt - d0), 68'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
